data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem.sv | 69 ++++++
 tb/tb_data_mem.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// Block-organised data memory: DEPTH blocks of BLOCK_SIZE bits, combinational dual read (index, index+1), synchronous full-block write.
// Optional macro DATA_MEM_READ_FORWARD_EN forwards pending write data onto reads of the block being written.
module data_mem #(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 256,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_SIZE-1:0]  in,
    input  logic                  readable,
    input  logic                  writable,
    input  logic [BLOCK_SIZE-1:0] write,
    output logic [BLOCK_SIZE-1:0] out1,
    output logic [BLOCK_SIZE-1:0] out2
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int HI_LSB = 5 + IDX_W;

    logic [BLOCK_SIZE-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_idx_next;
    logic                  w_unused_addr;

    // Byte offset and bits above the block index are dropped, which gives aliasing for free.
    assign w_idx      = in[5 +: IDX_W];
    assign w_idx_next = w_idx + IDX_W'(1);

    generate
        if (WORD_SIZE > HI_LSB) begin : g_hi_bits
            assign w_unused_addr = ^{in[4:0], in[WORD_SIZE-1:HI_LSB]};
        end else begin : g_no_hi_bits
            assign w_unused_addr = ^in[4:0];
        end
    endgenerate

    // NOTE: the whole array is cleared by the async reset, so it maps to flops, not a RAM macro.
    // NOTE: sequential state uses <= so every entry updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (writable) begin
            r_mem[w_idx] <= write;
        end
    end

    // NOTE: outputs get a default first so the combinational read never infers a latch.
    always_comb begin
        out1 = '0;
        out2 = '0;
        if (readable && !rst) begin
            out1 = r_mem[w_idx];
            out2 = r_mem[w_idx_next];
`ifdef DATA_MEM_READ_FORWARD_EN
            // out1 always targets the write block; out2 only does when DEPTH wraps onto itself.
            if (writable) begin
                out1 = write;
                if (w_idx_next == w_idx) begin
                    out2 = write;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed vector table, multi-cycle reset/forwarding sequences,
// and randomized traffic compared against a block-array reference model.
module tb_data_mem;

    localparam int WORD_SIZE  = 32;
    localparam int BLOCK_SIZE = 256;
    localparam int DEPTH      = 64;

`ifdef DATA_MEM_READ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef logic [BLOCK_SIZE-1:0] blk_t;

    typedef struct {
        string             name;
        bit                wr;
        logic [31:0]       waddr;
        blk_t              wdata;
        bit                rd;
        logic [31:0]       raddr;
        blk_t              exp1;
        blk_t              exp2;
    } vec_t;

    logic                 clk;
    logic                 rst;
    logic [WORD_SIZE-1:0] addr;
    logic                 readable;
    logic                 writable;
    blk_t                 wdata;
    blk_t                 out1;
    blk_t                 out2;

    blk_t model [DEPTH];
    int   n_checks;
    int   n_fail;

    data_mem #(
        .WORD_SIZE (WORD_SIZE),
        .BLOCK_SIZE(BLOCK_SIZE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (addr),
        .readable(readable),
        .writable(writable),
        .write   (wdata),
        .out1    (out1),
        .out2    (out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input blk_t act, input blk_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int blk_of(input logic [31:0] a);
        return int'((a / 32) % DEPTH);
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < BLOCK_SIZE / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endfunction

    // Expected outputs from the reading rules, given current inputs and the model contents.
    function automatic blk_t exp_read(input int which, input bit pre_edge);
        int   b;
        blk_t v;
        if (!readable || rst) return '0;
        b = (which == 1) ? blk_of(addr) : (blk_of(addr) + 1) % DEPTH;
        v = model[b];
        if (pre_edge && FWD && writable && b == blk_of(addr)) v = wdata;
        return v;
    endfunction

    task automatic do_write(input logic [31:0] a, input blk_t d);
        @(negedge clk);
        addr     = a;
        wdata    = d;
        writable = 1'b1;
        readable = 1'b0;
        @(posedge clk);
        #1;
        writable = 1'b0;
        model[blk_of(a)] = d;
    endtask

    vec_t vecs [8];
    blk_t pat_a5, pat_p, pat_q, pat_11, pat_22;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        addr     = '0;
        readable = 1'b0;
        writable = 1'b0;
        wdata    = '0;

        pat_a5 = {32{8'hA5}};
        pat_p  = {8{32'h12345678}};
        pat_q  = {8{32'hCAFEF00D}};
        pat_11 = {32{8'h11}};
        pat_22 = {32{8'h22}};

        vecs[0] = '{"reset_read",   0, 32'h0,   '0,     1, 32'h0,        '0,     '0};
        vecs[1] = '{"wr_a5_rd_3f",  1, 32'h20,  pat_a5, 1, 32'h3F,       pat_a5, '0};
        vecs[2] = '{"rd_0_out2",    0, 32'h0,   '0,     1, 32'h0,        '0,     pat_a5};
        vecs[3] = '{"wrap_7e0",     1, 32'h0,   pat_p,  1, 32'h7E0,      '0,     pat_p};
        vecs[4] = '{"alias_800",    0, 32'h0,   '0,     1, 32'h800,      pat_p,  pat_a5};
        vecs[5] = '{"rd_disabled",  0, 32'h0,   '0,     0, 32'h20,       '0,     '0};
        vecs[6] = '{"wr_last_blk",  1, 32'h7E0, pat_q,  1, 32'h7C0,      '0,     pat_q};
        vecs[7] = '{"alias_high",   0, 32'h0,   '0,     1, 32'hFFFF_FFE0, pat_q, pat_p};

        // Reset pulse.
        #2 rst = 1'b1;
        #6 rst = 1'b0;
        model_clear();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) do_write(vecs[i].waddr, vecs[i].wdata);
            @(negedge clk);
            addr     = vecs[i].raddr;
            readable = vecs[i].rd;
            #1;
            check({vecs[i].name, "_out1"}, out1, vecs[i].exp1);
            check({vecs[i].name, "_out2"}, out2, vecs[i].exp2);
        end

        // Reset with readable high forces zero outputs; a write pending at the edge under reset is lost.
        @(negedge clk);
        readable = 1'b1;
        addr     = 32'h20;
        #1;
        check("pre_rst_out1", out1, pat_a5);
        addr     = 32'h40;
        wdata    = {32{8'hFF}};
        writable = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_gates_out1", out1, '0);
        check("rst_gates_out2", out2, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        writable = 1'b0;
        model_clear();
        #1;
        check("rst_lost_wr", out1, '0);
        addr = 32'h20;
        #1;
        check("rst_cleared_blk1", out1, '0);
        addr = 32'h7E0;
        #1;
        check("rst_cleared_wrap", out2, '0);

        // Same-block read during write: old data (or forwarded data) before the edge, new data after.
        do_write(32'hA0, pat_11);
        @(negedge clk);
        readable = 1'b1;
        writable = 1'b1;
        addr     = 32'hA0;
        wdata    = pat_22;
        #1;
        check("rw_same_pre", out1, FWD ? pat_22 : pat_11);
        check("rw_same_pre_out2", out2, '0);
        @(posedge clk);
        #1;
        check("rw_same_post", out1, pat_22);
        writable = 1'b0;
        model[5] = pat_22;

        // Fill every block, then reset while clk is low: reads must drop to zero with no edge.
        for (int i = 0; i < DEPTH; i++) begin
            do_write(32'(i * 32), {8{32'(i) * 32'h0101_0101 ^ 32'hDEAD_BEEF}});
        end
        @(negedge clk);
        readable = 1'b1;
        addr     = 32'h3E0;
        #1;
        check("fill_rd_31", out1, {8{32'd31 * 32'h0101_0101 ^ 32'hDEAD_BEEF}});
        rst = 1'b1;
        #1;
        check("fill_rst_out1", out1, '0);
        check("fill_rst_out2", out2, '0);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            addr = 32'(i * 32);
            #0.1;
            check("fill_rst_sweep", out1, '0);
        end

        // Randomized traffic against the model.
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            addr     = $urandom;
            readable = 1'($urandom_range(0, 3) != 0);
            writable = 1'($urandom_range(0, 1));
            wdata    = rand_blk();
            #1;
            check("rand_pre_out1", out1, exp_read(1, 1'b1));
            check("rand_pre_out2", out2, exp_read(2, 1'b1));
            @(posedge clk);
            if (writable) model[blk_of(addr)] = wdata;
            #1;
            check("rand_post_out1", out1, exp_read(1, 1'b0));
            check("rand_post_out2", out2, exp_read(2, 1'b0));
        end
        writable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
